// File: rtl/sprite_fetcher.sv
// sprite_fetcher: reads a sprite from an SRAM sprite sheet and emits each non-transparent pixel
// at its screen position.
module sprite_fetcher #(
  parameter int          IMG_W     = 640,
  parameter logic [15:0] TRANS_KEY = 16'hF81F
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [9:0]  Draw_Idx_In,
  input  logic [9:0]  Width,
  input  logic [9:0]  Height,
  input  logic [9:0]  Dest_X,
  input  logic [9:0]  Dest_Y,
  output logic [9:0]  Draw_Idx,
  input  logic [10:0] SRAM_ADDR_X_Start,
  input  logic [10:0] SRAM_ADDR_Y_Start,
  output logic        Rd_Req,
  output logic [19:0] Rd_Addr,
  input  logic        Rd_Ack,
  input  logic [15:0] Rd_Data,
  output logic        Pix_Valid,
  input  logic        Pix_Ready,
  output logic [9:0]  Pix_X,
  output logic [9:0]  Pix_Y,
  output logic [15:0] Pix_Color,
  output logic        Busy,
  output logic        Done,
  input  logic        Abort
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, READ, EMIT, DONE} state_t;
  state_t state;
  logic [9:0] w, h, dx, dy, col, row, col_n, row_n;
  logic [10:0] xs, ys;
  logic [19:0] yy, xx;
  logic last_col, last;
  // 640 = 512 + 128, so the row pitch is two shifts and an add
  function automatic logic [19:0] pitch(input logic [19:0] y);
    return (IMG_W == 640) ? (y << 9) + (y << 7) : y * 20'(IMG_W);
  endfunction
  assign yy = 20'(ys) + 20'(row);
  assign xx = 20'(xs) + 20'(col);
  assign Rd_Addr = pitch(yy) + xx;
  assign Pix_X = dx + col;
  assign Pix_Y = dy + row;
  assign last_col = col == w - 10'd1;
  assign last = last_col && row == h - 10'd1;
  assign col_n = last_col ? 10'd0 : col + 10'd1;
  assign row_n = last_col ? row + 10'd1 : row;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      {w, h, dx, dy, col, row, Draw_Idx} <= '0;
      {xs, ys} <= '0;
      Pix_Color <= '0;
      {Busy, Done, Rd_Req, Pix_Valid} <= '0;
    end else begin
      Done <= 1'b0;
      if (Abort && state != IDLE) begin
        state <= IDLE;
        {Busy, Rd_Req, Pix_Valid} <= '0;
      end else
        case (state)
          IDLE: if (Start) begin
            {Draw_Idx, w, h, dx, dy} <= {Draw_Idx_In, Width, Height, Dest_X, Dest_Y};
            {col, row} <= '0;
            Busy <= 1'b1;
            state <= LOOKUP;
          end
          LOOKUP: begin
            {xs, ys} <= {SRAM_ADDR_X_Start, SRAM_ADDR_Y_Start};
            state <= CHECK;
          end
          CHECK: if (w == 10'd0 || h == 10'd0) begin
            Done <= 1'b1;
            state <= DONE;
          end else begin
            Rd_Req <= 1'b1;
            state <= READ;
          end
          READ: if (Rd_Ack) begin
            Pix_Color <= Rd_Data;
            if (Rd_Data == TRANS_KEY) begin
              {col, row} <= {col_n, row_n};
              Rd_Req <= !last;
              Done <= last;
              state <= last ? DONE : READ;
            end else begin
              Rd_Req <= 1'b0;
              Pix_Valid <= 1'b1;
              state <= EMIT;
            end
          end
          EMIT: if (Pix_Ready) begin
            {col, row} <= {col_n, row_n};
            Pix_Valid <= 1'b0;
            Rd_Req <= !last;
            Done <= last;
            state <= last ? DONE : READ;
          end
          DONE: begin
            Busy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_sprite_fetcher.sv
// tb_sprite_fetcher: table vectors, hand-built corner sequences and randomized jobs checked
// against a list-based model of the sprite walk.
module tb_sprite_fetcher;
  logic Clk = 1'b0, Reset_n, Start, Rd_Ack, Pix_Ready, Abort;
  logic [9:0] Draw_Idx_In, Width, Height, Dest_X, Dest_Y, Draw_Idx, Pix_X, Pix_Y;
  logic [10:0] SRAM_ADDR_X_Start, SRAM_ADDR_Y_Start;
  logic Rd_Req, Pix_Valid, Busy, Done;
  logic [19:0] Rd_Addr;
  logic [15:0] Rd_Data, Pix_Color;

  sprite_fetcher dut (.Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Draw_Idx_In(Draw_Idx_In),
    .Width(Width), .Height(Height), .Dest_X(Dest_X), .Dest_Y(Dest_Y), .Draw_Idx(Draw_Idx),
    .SRAM_ADDR_X_Start(SRAM_ADDR_X_Start), .SRAM_ADDR_Y_Start(SRAM_ADDR_Y_Start),
    .Rd_Req(Rd_Req), .Rd_Addr(Rd_Addr), .Rd_Ack(Rd_Ack), .Rd_Data(Rd_Data),
    .Pix_Valid(Pix_Valid), .Pix_Ready(Pix_Ready), .Pix_X(Pix_X), .Pix_Y(Pix_Y),
    .Pix_Color(Pix_Color), .Busy(Busy), .Done(Done), .Abort(Abort));

  always #5 Clk = ~Clk;

  function automatic int lx(input logic [9:0] i);
    return i == 10'd2 ? 213 : i == 10'd5 ? 2047 : int'(i) + 100;
  endfunction
  function automatic int ly(input logic [9:0] i);
    return i == 10'd2 ? 481 : i == 10'd5 ? 2047 : int'(i) / 2;
  endfunction
  assign SRAM_ADDR_X_Start = 11'(lx(Draw_Idx));
  assign SRAM_ADDR_Y_Start = 11'(ly(Draw_Idx));

  int n_vec = 0, n_bad = 0;
  bit hash_mode, trans_en;
  logic [19:0] trans_addr;
  int lat, rcnt, stall_left, rdy_pct, cyc, done_cnt, done_cyc;
  bit prev_ack, pv_wait, ra_wait;
  logic [35:0] pv_last;
  logic [19:0] ra_last;
  logic [19:0] rq[$];
  logic [35:0] pq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [19:0] a);
    if (hash_mode) return a[1:0] == 2'd0 ? 16'hF81F : a[15:0] ^ 16'h5A5A;
    return (trans_en && a == trans_addr) ? 16'hF81F : a[15:0] ^ 16'h1234;
  endfunction

  task automatic env_clear();
    rq.delete(); pq.delete();
    {prev_ack, pv_wait, ra_wait} = '0;
    rcnt = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    Rd_Ack = 0; Pix_Ready = 0;
  endtask

  // one cycle of SRAM slave and pixel sink, evaluated at the falling edge
  task automatic step();
    bit r;
    chk("mutex", {63'd0, Rd_Req & Pix_Valid}, 64'd0);
    if (Done) begin done_cnt++; done_cyc = cyc; end
    if (pv_wait && Pix_Valid) chk("pix_stable", {Pix_X, Pix_Y, Pix_Color}, pv_last);
    if (ra_wait && Rd_Req) chk("addr_stable", Rd_Addr, ra_last);
    r = (stall_left > 0 && Pix_Valid) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    if (Pix_Valid && stall_left > 0) stall_left--;
    Pix_Ready = r;
    if (Pix_Valid && Pix_Ready && !Abort) pq.push_back({Pix_X, Pix_Y, Pix_Color});
    pv_wait = Pix_Valid && !Pix_Ready;
    pv_last = {Pix_X, Pix_Y, Pix_Color};
    Rd_Ack = 0;
    Rd_Data = 16'($urandom);
    if (prev_ack) rcnt = 0;
    if (Rd_Req) begin
      if (rcnt >= lat) begin
        Rd_Ack = 1;
        Rd_Data = mem(Rd_Addr);
        if (!Abort) rq.push_back(Rd_Addr);
      end else rcnt++;
    end else rcnt = 0;
    prev_ack = Rd_Ack;
    ra_wait = Rd_Req && !Rd_Ack;
    ra_last = Rd_Addr;
    cyc++;
  endtask

  task automatic launch(input logic [9:0] idx, w, h, dx, dy);
    env_clear();
    @(negedge Clk);
    {Draw_Idx_In, Width, Height, Dest_X, Dest_Y} = {idx, w, h, dx, dy};
    Start = 1;
    step();
    @(negedge Clk);
    Start = 0;
    step();
  endtask

  task automatic run_job(input logic [9:0] idx, w, h, dx, dy);
    int guard = 0;
    launch(idx, w, h, dx, dy);
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge Clk);
      step();
      guard++;
    end
    chk("done_seen", done_cnt, 1);
    @(negedge Clk);
    step();
    chk("busy_after_done", {63'd0, Busy}, 0);
    chk("done_once", done_cnt, 1);
  endtask

  task automatic model_check(input logic [9:0] idx, w, h, dx, dy);
    logic [19:0] ea[$];
    logic [35:0] ep[$];
    logic [19:0] a;
    for (int r = 0; r < int'(h); r++)
      for (int c = 0; c < int'(w); c++) begin
        a = 20'((ly(idx) + r) * 640 + lx(idx) + c);
        ea.push_back(a);
        if (mem(a) != 16'hF81F) ep.push_back({10'(int'(dx) + c), 10'(int'(dy) + r), mem(a)});
      end
    chk("n_reads", rq.size(), ea.size());
    for (int i = 0; i < ea.size() && i < rq.size(); i++) chk("read_addr", rq[i], ea[i]);
    chk("n_pixels", pq.size(), ep.size());
    for (int i = 0; i < ep.size() && i < pq.size(); i++) chk("pixel", pq[i], ep[i]);
  endtask

  typedef struct {
    logic [9:0] idx, w, h, dx, dy;
    bit ten;
    logic [19:0] ta;
    int nrd, npx;
    logic [19:0] a0;
    logic [9:0] lastx, lasty;
    int dlat;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{2, 2, 2, 10, 20, 0, 0, 4, 4, 308053, 11, 21, 0};
    tbl[1] = '{2, 2, 2, 10, 20, 1, 308054, 4, 3, 308053, 11, 21, 0};
    tbl[2] = '{2, 0, 5, 10, 20, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[3] = '{2, 2, 1, 1023, 5, 0, 0, 2, 2, 308053, 0, 5, 0};
    tbl[4] = '{2, 1, 3, 0, 1022, 0, 0, 3, 3, 308053, 0, 0, 0};
    tbl[5] = '{2, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[6] = '{5, 1, 1, 3, 4, 0, 0, 1, 1, 263551, 3, 4, 0};
    {Start, Abort, Rd_Ack, Pix_Ready} = '0;
    {Draw_Idx_In, Width, Height, Dest_X, Dest_Y} = '0;
    Rd_Data = 0;
    {hash_mode, trans_en} = '0;
    trans_addr = 0; lat = 1; rdy_pct = 100; stall_left = 0;
    env_clear();
    Reset_n = 0;
    repeat (3) @(negedge Clk);
    chk("rst_ctl", {Busy, Done, Rd_Req, Pix_Valid}, 0);
    chk("rst_data", {Rd_Addr, Pix_X, Pix_Y, Pix_Color, Draw_Idx}, 0);
    Reset_n = 1;
    // a stray acknowledge while idle must be ignored
    Rd_Ack = 1; Rd_Data = 16'h1111;
    repeat (3) @(negedge Clk);
    chk("stray_ack", {Busy, Rd_Req, Pix_Valid}, 0);
    Rd_Ack = 0;

    foreach (tbl[i]) begin
      trans_en = tbl[i].ten; trans_addr = tbl[i].ta;
      run_job(tbl[i].idx, tbl[i].w, tbl[i].h, tbl[i].dx, tbl[i].dy);
      chk("tbl_nreads", rq.size(), tbl[i].nrd);
      chk("tbl_npix", pq.size(), tbl[i].npx);
      if (tbl[i].nrd > 0) chk("tbl_first_addr", rq[0], tbl[i].a0);
      if (tbl[i].npx > 0) chk("tbl_last_pix", {pq[pq.size()-1][35:26], pq[pq.size()-1][25:16]},
                              {tbl[i].lastx, tbl[i].lasty});
      if (tbl[i].dlat > 0) chk("tbl_done_lat", done_cyc, tbl[i].dlat);
      model_check(tbl[i].idx, tbl[i].w, tbl[i].h, tbl[i].dx, tbl[i].dy);
    end
    trans_en = 0;

    // sink stalls the first pixel for five cycles
    stall_left = 5;
    run_job(2, 2, 1, 10, 20);
    chk("stall_used", stall_left, 0);
    model_check(2, 2, 1, 10, 20);

    // abort in READ in the same cycle as Rd_Ack
    begin
      int g = 0;
      lat = 0;
      launch(2, 3, 2, 7, 8);
      while (!Abort && g < 50) begin
        @(negedge Clk);
        Abort = Rd_Req;
        step();
        g++;
      end
      chk("abort_reached", {63'd0, Abort}, 1);
      @(negedge Clk);
      Abort = 0;
      chk("abort_idle", {Busy, Rd_Req, Pix_Valid}, 0);
      repeat (6) begin @(negedge Clk); step(); end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_no_pix", pq.size(), 0);
    end
    lat = 1;
    run_job(2, 2, 2, 10, 20);
    model_check(2, 2, 2, 10, 20);

    // reset asserted mid-sprite while a read is pending
    begin
      int g = 0;
      lat = 3;
      launch(2, 2, 2, 30, 40);
      while (!Rd_Req && g < 50) begin @(negedge Clk); step(); g++; end
      chk("rst_reached_read", {63'd0, Rd_Req}, 1);
      #1 Reset_n = 0;
      #1 chk("rst_mid_ctl", {Busy, Done, Rd_Req, Pix_Valid}, 0);
      chk("rst_mid_data", {Rd_Addr, Draw_Idx, Pix_X, Pix_Y}, 0);
      @(negedge Clk);
      Reset_n = 1;
      env_clear();
      repeat (6) begin @(negedge Clk); step(); end
      chk("rst_no_done", done_cnt, 0);
      chk("rst_no_pix", pq.size(), 0);
    end
    lat = 1;
    run_job(2, 2, 2, 10, 20);
    model_check(2, 2, 2, 10, 20);

    hash_mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [9:0] idx, w, h, dx, dy;
      idx = 10'($urandom); dx = 10'($urandom); dy = 10'($urandom);
      w = 10'($urandom_range(0, 4)); h = 10'($urandom_range(0, 4));
      lat = $urandom_range(0, 2);
      rdy_pct = $urandom_range(30, 100);
      stall_left = (k % 5 == 0) ? 3 : 0;
      run_job(idx, w, h, dx, dy);
      model_check(idx, w, h, dx, dy);
      if (w == 0 || h == 0) chk("rand_done_lat", done_cyc, 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
